// File: rtl/xy_input_cond.sv
// xy_input_cond
//   Conditions two raw asynchronous inputs for an x/y-driven Mealy machine.
//   Each channel goes through a 2-flop synchroniser and a counter-based
//   debouncer. Each debounced rising edge then becomes a single-cycle pulse.
//   When both channels rise together, x goes first and y is deferred by one
//   cycle, so x and y are never high in the same cycle.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   x_raw    in   raw asynchronous x input
//   y_raw    in   raw asynchronous y input
//   x        out  registered one-cycle pulse per accepted x rise
//   y        out  registered one-cycle pulse per accepted y rise
//   x_level  out  debounced x level
//   y_level  out  debounced y level
//   y_pend   out  a y pulse is being held back by arbitration
module xy_input_cond #(
  parameter int unsigned DB_CNT = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic x_raw,
  input  logic y_raw,
  output logic x,
  output logic y,
  output logic x_level,
  output logic y_level,
  output logic y_pend
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

  logic             x_meta_q, x_sync_q, y_meta_q, y_sync_q;
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic             x_lvl_q, x_lvl_d, y_lvl_q, y_lvl_d;
  logic             x_lvl_dly_q, y_lvl_dly_q;
  logic             x_q, x_d, y_q, y_d, y_pend_q, y_pend_d;
  logic             x_req, y_req;

  // Debounce: the counter only advances while the synchronised input
  // disagrees with the accepted level; any agreement restarts it.
  always_comb begin
    x_cnt_d = x_cnt_q;
    x_lvl_d = x_lvl_q;
    if (x_sync_q == x_lvl_q) begin
      x_cnt_d = '0;
    end else if (x_cnt_q == CNT_LAST) begin
      x_lvl_d = x_sync_q;
      x_cnt_d = '0;
    end else begin
      x_cnt_d = x_cnt_q + 1'b1;
    end
  end

  always_comb begin
    y_cnt_d = y_cnt_q;
    y_lvl_d = y_lvl_q;
    if (y_sync_q == y_lvl_q) begin
      y_cnt_d = '0;
    end else if (y_cnt_q == CNT_LAST) begin
      y_lvl_d = y_sync_q;
      y_cnt_d = '0;
    end else begin
      y_cnt_d = y_cnt_q + 1'b1;
    end
  end

  assign x_req = x_lvl_q & ~x_lvl_dly_q;
  assign y_req = y_lvl_q & ~y_lvl_dly_q;

  // x has priority; a colliding y request is parked in y_pend and served
  // the next cycle. A fresh x request cannot land in that cycle because
  // x_level has only just risen.
  always_comb begin
    x_d      = 1'b0;
    y_d      = 1'b0;
    y_pend_d = y_pend_q;
    if (x_req) begin
      x_d = 1'b1;
      if (y_req) y_pend_d = 1'b1;
    end else if (y_req || y_pend_q) begin
      y_d      = 1'b1;
      y_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_meta_q    <= 1'b0;
      x_sync_q    <= 1'b0;
      y_meta_q    <= 1'b0;
      y_sync_q    <= 1'b0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      x_lvl_q     <= 1'b0;
      y_lvl_q     <= 1'b0;
      x_lvl_dly_q <= 1'b0;
      y_lvl_dly_q <= 1'b0;
      x_q         <= 1'b0;
      y_q         <= 1'b0;
      y_pend_q    <= 1'b0;
    end else begin
      x_meta_q    <= x_raw;
      x_sync_q    <= x_meta_q;
      y_meta_q    <= y_raw;
      y_sync_q    <= y_meta_q;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      x_lvl_q     <= x_lvl_d;
      y_lvl_q     <= y_lvl_d;
      x_lvl_dly_q <= x_lvl_q;
      y_lvl_dly_q <= y_lvl_q;
      x_q         <= x_d;
      y_q         <= y_d;
      y_pend_q    <= y_pend_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign x_level = x_lvl_q;
  assign y_level = y_lvl_q;
  assign y_pend  = y_pend_q;

endmodule

// File: tb/tb_xy_input_cond.sv
// Testbench for xy_input_cond with DB_CNT = 4.
// Stimulus pushes expected pulses (channel, cycle) into a queue; a monitor
// pops one entry per observed x/y pulse. Raw changes are applied 1 time unit
// after edge e0; a rise then shows x_level after edge e0+6 and the pulse
// in the cycle after edge e0+7.
module tb_xy_input_cond;

  logic clk = 1'b0;
  logic rst;
  logic x_raw, y_raw;
  logic x, y, x_level, y_level, y_pend;

  typedef struct {
    bit          ch;   // 0 = x, 1 = y
    int unsigned cyc;
  } ev_t;

  ev_t         sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          done = 1'b0;

  xy_input_cond #(.DB_CNT(4), .CNT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .x_raw  (x_raw),
    .y_raw  (y_raw),
    .x      (x),
    .y      (y),
    .x_level(x_level),
    .y_level(y_level),
    .y_pend (y_pend)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input bit ch, input int unsigned c);
    ev_t e;
    e.ch  = ch;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Bounce pattern: runs of 1..3 cycles (too short to be accepted), then a
  // clean rise at index f held for 15 cycles, then low for the remainder.
  task automatic build(output bit [59:0] a, output int f);
    int pos;
    int stop;
    int seg;
    bit val;
    a    = '0;
    pos  = $urandom_range(0, 5);
    stop = pos + $urandom_range(0, 12);
    val  = 1'b1;
    while (pos < stop) begin
      seg = $urandom_range(1, 3);
      for (int k = 0; k < seg; k++) a[pos + k] = val;
      pos += seg;
      val  = ~val;
    end
    if (val == 1'b0) begin
      a[pos] = 1'b0;
      pos++;
    end
    f = pos;
    for (int k = 0; k < 15; k++) a[f + k] = 1'b1;
  endtask

  initial begin
    int unsigned e0;
    int unsigned e1;
    bit [59:0]   ax;
    bit [59:0]   ay;
    int          fx;
    int          fy;
    int unsigned tx;
    int unsigned ty;
    ev_t         ev;

    rst   = 1'b0;
    x_raw = 1'b1;
    y_raw = 1'b1;

    fork
      begin : stim
        // Reset with both inputs held high, then release.
        step(3);
        chk("reset_outs", {x, y, x_level, y_level, y_pend}, 5'b00000);
        rst = 1'b1;
        e0  = cyc;
        expect_ev(1'b0, e0 + 7);
        expect_ev(1'b1, e0 + 8);
        step(5);
        chk("rst_lvl_e5", {x_level, y_level}, 2'b00);
        step(1);
        chk("rst_lvl_e6", {x_level, y_level}, 2'b11);
        step(1);
        chk("rst_ypend_set", y_pend, 1);
        step(1);
        chk("rst_ypend_clr", y_pend, 0);
        x_raw = 1'b0;
        y_raw = 1'b0;
        step(15);
        chk("rst_lvl_fall", {x_level, y_level}, 2'b00);

        // Clean press on x, held 100 cycles: exactly one pulse.
        x_raw = 1'b1;
        e0    = cyc;
        expect_ev(1'b0, e0 + 7);
        step(5);
        chk("clean_lvl_e5", x_level, 0);
        step(1);
        chk("clean_lvl_e6", x_level, 1);
        step(100);
        chk("clean_lvl_held", x_level, 1);
        x_raw = 1'b0;
        step(15);
        chk("clean_lvl_fall", x_level, 0);

        // Glitches of 3, 4 and 5 cycles.
        for (int w = 3; w <= 5; w++) begin
          x_raw = 1'b1;
          e0    = cyc;
          if (w >= 4) expect_ev(1'b0, e0 + 7);
          step(w);
          x_raw = 1'b0;
          step(6 - w);
          chk($sformatf("glitch%0d_lvl", w), x_level, (w >= 4) ? 1 : 0);
          step(20);
          chk($sformatf("glitch%0d_lvl_end", w), x_level, 0);
        end

        // Simultaneous press.
        x_raw = 1'b1;
        y_raw = 1'b1;
        e0    = cyc;
        expect_ev(1'b0, e0 + 7);
        expect_ev(1'b1, e0 + 8);
        step(7);
        chk("simul_ypend_n", y_pend, 1);
        step(1);
        chk("simul_ypend_n1", y_pend, 0);
        x_raw = 1'b0;
        y_raw = 1'b0;
        step(15);

        // Reset while y is deferred: the deferred y is discarded.
        x_raw = 1'b1;
        y_raw = 1'b1;
        e0    = cyc;
        expect_ev(1'b0, e0 + 7);
        step(7);
        chk("rstmid_ypend", y_pend, 1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rstmid_async", {x, y, x_level, y_level, y_pend}, 5'b00000);
        step(3);
        rst = 1'b1;
        e1  = cyc;
        expect_ev(1'b0, e1 + 7);
        expect_ev(1'b1, e1 + 8);
        step(5);
        chk("rstmid_relatch_e5", {x_level, y_level}, 2'b00);
        step(1);
        chk("rstmid_relatch_e6", {x_level, y_level}, 2'b11);
        step(3);
        x_raw = 1'b0;
        y_raw = 1'b0;
        step(15);

        // Reset in the middle of a debounce count.
        x_raw = 1'b1;
        step(3);
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        e1  = cyc;
        expect_ev(1'b0, e1 + 7);
        step(5);
        chk("dbmid_lvl_e5", x_level, 0);
        step(1);
        chk("dbmid_lvl_e6", x_level, 1);
        step(2);
        x_raw = 1'b0;
        step(15);

        // Bounce bursts on both channels.
        for (int b = 0; b < 30; b++) begin
          build(ax, fx);
          build(ay, fy);
          for (int i = 0; i < 60; i++) begin
            x_raw = ax[i];
            y_raw = ay[i];
            if (i == 0) begin
              e0 = cyc;
              tx = e0 + 7 + fx;
              ty = e0 + 7 + fy;
              if (ty == tx) ty = tx + 1;
              if (tx < ty) begin
                expect_ev(1'b0, tx);
                expect_ev(1'b1, ty);
              end else begin
                expect_ev(1'b1, ty);
                expect_ev(1'b0, tx);
              end
            end
            step(1);
          end
        end
        x_raw = 1'b0;
        y_raw = 1'b0;
        step(10);
        chk("sb_drain", sb.size(), 0);
        done = 1'b1;
      end

      begin : mon
        while (!done) begin
          @(negedge clk);
          checks++;
          if (x && y) begin
            errors++;
            $display("FAIL xy_excl actual x=%0b y=%0b required not both (cyc %0d)", x, y, cyc);
          end
          if (x || y) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL pulse_unexpected actual ch=%0d cyc=%0d required none", y ? 1 : 0, cyc);
            end else begin
              ev = sb.pop_front();
              if ((x ? 1'b0 : 1'b1) !== ev.ch || cyc !== ev.cyc) begin
                errors++;
                $display("FAIL pulse actual ch=%0d cyc=%0d required ch=%0d cyc=%0d",
                         x ? 0 : 1, cyc, ev.ch, ev.cyc);
              end
            end
          end
        end
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
